pipe_stage_reg: RTL and testbench

Generic, parametrised pipeline-stage register that replaces the hand-written per-stage latches between core stages (IF/ID … MEM/WB). It carries an arbitrary packed payload with a valid/ready handshake. It supports a synchronous flush and an optional 2-entry skid mode, so that ready is registered and throughput is full. It also exposes a saturating back-pressure counter for performance analysis.

---
 rtl/core_pipe_pkg.sv | 38 +++
 rtl/pipe_stage_reg_if.sv | 31 +++
 rtl/pipe_sat_counter.sv | 35 +++
 rtl/pipe_stage_reg.sv | 204 ++++++++++++++++++++
 tb/tb_pipe_stage_reg.sv | 286 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/core_pipe_pkg.sv
// ---------------------------------------------------------------------------
// core_pipe_pkg
// Shared definitions for the core's inter-stage pipeline registers.
//   pipe_state_e : occupancy of a skid-mode stage register
//                  (ST_EMPTY = 0, ST_ONE = 1, ST_TWO = 2)
//   *_W          : payload widths of the individual stage boundaries; callers
//                  pack their fields into in_data with these widths
//   *_t          : packed payload layouts for the stage boundaries
// ---------------------------------------------------------------------------
package core_pipe_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } pipe_state_e;

  localparam int XLEN = 32;

  // IF/ID carries the fetch PC and the raw instruction word.
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [31:0]     instr;
  } if_id_t;

  // MEM/WB carries the register write-back request.
  typedef struct packed {
    logic            rd_wen;
    logic [4:0]      rd_waddr;
    logic [XLEN-1:0] alu_result;
  } mem_wb_t;

  localparam int IF_ID_W  = $bits(if_id_t);
  localparam int ID_EX_W  = 2 * XLEN + 2 * XLEN + 5 + 8;
  localparam int EX_MEM_W = XLEN + XLEN + 5 + 4;
  localparam int MEM_WB_W = $bits(mem_wb_t);

endpackage

// File: rtl/pipe_stage_reg_if.sv
// ---------------------------------------------------------------------------
// pipe_stage_reg_if
// Valid/ready payload channel between two pipeline stages.
//   valid : producer holds a valid beat
//   ready : consumer accepts the beat this cycle
//   data  : DATA_W-bit payload
// Modports:
//   master : producer side (drives valid/data, samples ready)
//   slave  : consumer side (samples valid/data, drives ready)
// ---------------------------------------------------------------------------
interface pipe_stage_reg_if #(
  parameter int DATA_W = 32
);

  logic              valid;
  logic              ready;
  logic [DATA_W-1:0] data;

  modport master (
    output valid,
    output data,
    input  ready
  );

  modport slave (
    input  valid,
    input  data,
    output ready
  );

endinterface

// File: rtl/pipe_sat_counter.sv
// ---------------------------------------------------------------------------
// pipe_sat_counter
// Saturating event counter used by the pipeline performance monitors.
//   clk : clock, rising edge
//   rst : asynchronous active-high reset, clears the count
//   inc : count one event this cycle
//   clr : synchronous clear, wins over a simultaneous inc
//   cnt : current count, sticks at all-ones instead of wrapping
// ---------------------------------------------------------------------------
module pipe_sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  // Count events until the all-ones value is reached, then hold there so a
  // long stall never reads back as a short one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != CNT_MAX)) begin
      cnt <= cnt + CNT_ONE;
    end
  end

endmodule

// File: rtl/pipe_stage_reg.sv
// ---------------------------------------------------------------------------
// pipe_stage_reg
// Generic pipeline-stage register with valid/ready handshake, synchronous
// flush, optional 2-entry skid buffer and a saturating back-pressure counter.
// Parameters:
//   DATA_W     : payload width (1..512)
//   SKID       : 0 = single register, in_ready combinational from out_ready
//                1 = main + skid register, in_ready registered
//   RESET_DATA : 1 = payload registers cleared by reset, 0 = not reset
//   CNT_W      : width of stall_cnt
// Ports:
//   clk, rst  : clock (rising edge) and asynchronous active-high reset
//   flush     : synchronous kill of every held entry and the incoming beat
//   up        : upstream channel (slave), up.ready is the stage's in_ready
//   dn        : downstream channel (master), dn.data is the oldest entry
//   cnt_clr   : synchronous clear of stall_cnt
//   stall_cnt : cycles spent with dn.valid=1 and dn.ready=0, saturating
// ---------------------------------------------------------------------------
module pipe_stage_reg
  import core_pipe_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int SKID       = 0,
  parameter int RESET_DATA = 0,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  pipe_stage_reg_if.slave  up,
  pipe_stage_reg_if.master dn,
  input  logic             cnt_clr,
  output logic [CNT_W-1:0] stall_cnt
);

  // Main register: always the oldest entry, drives the downstream side.
  logic              main_valid;
  logic              main_en;
  logic [DATA_W-1:0] main_d;
  logic [DATA_W-1:0] main_q;
  logic              stall_inc;

  assign dn.valid = main_valid;
  assign dn.data  = main_q;

  // Main payload register. Without RESET_DATA it has no reset at all so it
  // can map onto plain enable flops.
  if (RESET_DATA != 0) begin : g_main_rst
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        main_q <= '0;
      end else if (main_en) begin
        main_q <= main_d;
      end
    end
  end else begin : g_main_nrst
    always_ff @(posedge clk) begin
      if (main_en) begin
        main_q <= main_d;
      end
    end
  end

  if (SKID == 0) begin : g_single
    logic ready_c;
    logic in_xfer;
    logic out_xfer;

    // The slot frees up in the same cycle the downstream takes the beat,
    // which is what gives full throughput without a second entry.
    assign ready_c  = ~main_valid | dn.ready;
    assign up.ready = ready_c;
    assign in_xfer  = up.valid & ready_c;
    assign out_xfer = main_valid & dn.ready;
    assign main_en  = in_xfer & ~flush;
    assign main_d   = up.data;

    // Valid bit: a load always wins over a drain, flush kills both.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        main_valid <= 1'b0;
      end else if (flush) begin
        main_valid <= 1'b0;
      end else if (in_xfer) begin
        main_valid <= 1'b1;
      end else if (out_xfer) begin
        main_valid <= 1'b0;
      end
    end
  end else begin : g_skid
    pipe_state_e       state_q;
    logic              ready_q;
    logic              in_xfer;
    logic              out_xfer;
    logic              skid_en;
    logic [DATA_W-1:0] skid_q;

    assign up.ready = ready_q;
    assign in_xfer  = up.valid & ready_q;
    assign out_xfer = main_valid & dn.ready;

    // Occupancy FSM. ready_q and main_valid are registered alongside the
    // state so in_ready never sees out_ready combinationally; the skid entry
    // exists to absorb the one beat accepted while ready_q is stale.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        state_q    <= ST_EMPTY;
        main_valid <= 1'b0;
        ready_q    <= 1'b1;
      end else if (flush) begin
        state_q    <= ST_EMPTY;
        main_valid <= 1'b0;
        ready_q    <= 1'b1;
      end else begin
        case (state_q)
          ST_EMPTY: begin
            if (in_xfer) begin
              state_q    <= ST_ONE;
              main_valid <= 1'b1;
            end
          end
          ST_ONE: begin
            if (in_xfer && !out_xfer) begin
              state_q <= ST_TWO;
              ready_q <= 1'b0;
            end else if (!in_xfer && out_xfer) begin
              state_q    <= ST_EMPTY;
              main_valid <= 1'b0;
            end
          end
          ST_TWO: begin
            if (out_xfer) begin
              state_q <= ST_ONE;
              ready_q <= 1'b1;
            end
          end
          default: begin
            state_q    <= ST_EMPTY;
            main_valid <= 1'b0;
            ready_q    <= 1'b1;
          end
        endcase
      end
    end

    // Payload steering: main refills from upstream when it is empty or being
    // drained, the skid entry catches the beat that arrives while main is
    // stuck, and main takes the skid entry once it drains. Flush leaves the
    // payload registers alone.
    always_comb begin
      main_en = 1'b0;
      main_d  = up.data;
      skid_en = 1'b0;
      if (!flush) begin
        case (state_q)
          ST_EMPTY: begin
            main_en = in_xfer;
          end
          ST_ONE: begin
            main_en = in_xfer & out_xfer;
            skid_en = in_xfer & ~out_xfer;
          end
          ST_TWO: begin
            main_en = out_xfer;
            main_d  = skid_q;
          end
          default: begin
            main_en = 1'b0;
          end
        endcase
      end
    end

    // Skid payload register, reset behaviour follows the main register.
    if (RESET_DATA != 0) begin : g_skid_rst
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          skid_q <= '0;
        end else if (skid_en) begin
          skid_q <= up.data;
        end
      end
    end else begin : g_skid_nrst
      always_ff @(posedge clk) begin
        if (skid_en) begin
          skid_q <= up.data;
        end
      end
    end
  end

  assign stall_inc = main_valid & ~dn.ready;

  pipe_sat_counter #(
    .CNT_W (CNT_W)
  ) u_stall_cnt (
    .clk (clk),
    .rst (rst),
    .inc (stall_inc),
    .clr (cnt_clr),
    .cnt (stall_cnt)
  );

endmodule

// File: tb/tb_pipe_stage_reg.sv
// ---------------------------------------------------------------------------
// tb_pipe_stage_reg
// Drives one shared stimulus stream into three stage registers:
//   dut_a : SKID=0, RESET_DATA=1, CNT_W=16
//   dut_b : SKID=1, RESET_DATA=0, CNT_W=16
//   dut_c : SKID=1, RESET_DATA=1, CNT_W=4
// Each DUT is mirrored by a small FIFO model (capacity 1 or 2) that predicts
// valid, ready, data and the stall count every cycle; directed literal
// expectations pin the model at the interesting points.
// ---------------------------------------------------------------------------
module tb_pipe_stage_reg;

  localparam int DW = 32;

  logic          clk;
  logic          rst;
  logic          flush;
  logic          cnt_clr;
  logic          in_valid;
  logic [DW-1:0] in_data;
  logic          out_ready;
  logic [15:0]   stall_a;
  logic [15:0]   stall_b;
  logic [3:0]    stall_c;

  int tests_run;
  int tests_failed;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  pipe_stage_reg_if #(.DATA_W(DW)) up_a ();
  pipe_stage_reg_if #(.DATA_W(DW)) dn_a ();
  pipe_stage_reg_if #(.DATA_W(DW)) up_b ();
  pipe_stage_reg_if #(.DATA_W(DW)) dn_b ();
  pipe_stage_reg_if #(.DATA_W(DW)) up_c ();
  pipe_stage_reg_if #(.DATA_W(DW)) dn_c ();

  assign up_a.valid = in_valid;
  assign up_a.data  = in_data;
  assign dn_a.ready = out_ready;
  assign up_b.valid = in_valid;
  assign up_b.data  = in_data;
  assign dn_b.ready = out_ready;
  assign up_c.valid = in_valid;
  assign up_c.data  = in_data;
  assign dn_c.ready = out_ready;

  pipe_stage_reg #(.DATA_W(DW), .SKID(0), .RESET_DATA(1), .CNT_W(16)) dut_a (
    .clk(clk), .rst(rst), .flush(flush), .up(up_a), .dn(dn_a),
    .cnt_clr(cnt_clr), .stall_cnt(stall_a)
  );

  pipe_stage_reg #(.DATA_W(DW), .SKID(1), .RESET_DATA(0), .CNT_W(16)) dut_b (
    .clk(clk), .rst(rst), .flush(flush), .up(up_b), .dn(dn_b),
    .cnt_clr(cnt_clr), .stall_cnt(stall_b)
  );

  pipe_stage_reg #(.DATA_W(DW), .SKID(1), .RESET_DATA(1), .CNT_W(4)) dut_c (
    .clk(clk), .rst(rst), .flush(flush), .up(up_c), .dn(dn_c),
    .cnt_clr(cnt_clr), .stall_cnt(stall_c)
  );

  // Model: per DUT a FIFO of held beats (oldest first) and a stall count.
  logic [DW-1:0] mbuf [3][2];
  int            msize [3];
  int            mstall [3];

  function automatic int stallMax(input int k);
    return (k == 2) ? 15 : 65535;
  endfunction

  function automatic bit isSkid(input int k);
    return k != 0;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [DW-1:0] d, input logic ordy,
                               input logic fl, input logic clr);
    @(posedge clk);
    #1;
    in_valid  = v;
    in_data   = d;
    out_ready = ordy;
    flush     = fl;
    cnt_clr   = clr;
  endtask

  // Every falling edge: compare all DUTs against the model, then advance the
  // model by the transfers the coming rising edge will perform.
  always @(negedge clk) begin : compare
    logic          ov  [3];
    logic          ordy [3];
    logic [DW-1:0] od  [3];
    logic [31:0]   oc  [3];
    bit            exp_ready;
    bit            out_x;
    bit            in_x;

    ov[0] = dn_a.valid;  ordy[0] = up_a.ready;  od[0] = dn_a.data;  oc[0] = 32'(stall_a);
    ov[1] = dn_b.valid;  ordy[1] = up_b.ready;  od[1] = dn_b.data;  oc[1] = 32'(stall_b);
    ov[2] = dn_c.valid;  ordy[2] = up_c.ready;  od[2] = dn_c.data;  oc[2] = 32'(stall_c);

    for (int k = 0; k < 3; k++) begin
      if (rst) begin
        msize[k]  = 0;
        mstall[k] = 0;
        checkOutput($sformatf("rst_valid[%0d]", k), 32'(ov[k]), 32'd0);
        checkOutput($sformatf("rst_stall[%0d]", k), oc[k], 32'd0);
      end else begin
        exp_ready = isSkid(k) ? (msize[k] < 2) : ((msize[k] == 0) || out_ready);
        checkOutput($sformatf("valid[%0d]", k), 32'(ov[k]), 32'(msize[k] > 0));
        checkOutput($sformatf("ready[%0d]", k), 32'(ordy[k]), 32'(exp_ready));
        checkOutput($sformatf("stall[%0d]", k), oc[k], 32'(mstall[k]));
        if (msize[k] > 0) begin
          checkOutput($sformatf("data[%0d]", k), od[k], mbuf[k][0]);
        end

        out_x = (msize[k] > 0) && out_ready;
        in_x  = in_valid && exp_ready;

        if (cnt_clr) begin
          mstall[k] = 0;
        end else if ((msize[k] > 0) && !out_ready && (mstall[k] < stallMax(k))) begin
          mstall[k] = mstall[k] + 1;
        end

        if (flush) begin
          msize[k] = 0;
        end else begin
          if (out_x) begin
            mbuf[k][0] = mbuf[k][1];
            msize[k]   = msize[k] - 1;
          end
          if (in_x) begin
            mbuf[k][msize[k]] = in_data;
            msize[k]          = msize[k] + 1;
          end
        end
      end
    end
  end

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst       = 1'b0;
    flush     = 1'b0;
    cnt_clr   = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;

    // Reset held with a beat offered.
    #2;
    rst      = 1'b1;
    in_valid = 1'b1;
    in_data  = 32'hDEAD_BEEF;
    repeat (3) @(posedge clk);
    #2;
    checkOutput("reset_valid_a", 32'(dn_a.valid), 32'd0);
    checkOutput("reset_valid_b", 32'(dn_b.valid), 32'd0);
    checkOutput("reset_data_a", dn_a.data, 32'd0);
    checkOutput("reset_data_c", dn_c.data, 32'd0);
    checkOutput("reset_stall_b", 32'(stall_b), 32'd0);
    @(posedge clk);
    #1;
    rst      = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    #1;
    checkOutput("release_ready_a", 32'(up_a.ready), 32'd1);
    checkOutput("release_ready_b", 32'(up_b.ready), 32'd1);
    checkOutput("release_ready_c", 32'(up_c.ready), 32'd1);

    // Streaming 1..8 with the downstream always ready.
    for (int i = 1; i <= 8; i++) begin
      applyStimulus(1'b1, DW'(i), 1'b1, 1'b0, 1'b0);
      #1;
      if (i > 1) begin
        checkOutput("stream_data_a", dn_a.data, 32'(i - 1));
        checkOutput("stream_data_b", dn_b.data, 32'(i - 1));
        checkOutput("stream_valid_c", 32'(dn_c.valid), 32'd1);
      end
    end
    applyStimulus(1'b0, '0, 1'b1, 1'b0, 1'b0);
    #1;
    checkOutput("stream_last_a", dn_a.data, 32'd8);
    checkOutput("stream_last_b", dn_b.data, 32'd8);

    // Back-pressure: 1,2 fill the skid stage, 3 waits upstream.
    applyStimulus(1'b1, 32'd1, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'd2, 1'b0, 1'b0, 1'b0);
    #1;
    checkOutput("bp_ready_one_b", 32'(up_b.ready), 32'd1);
    checkOutput("bp_head_b", dn_b.data, 32'd1);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 32'd3, 1'b0, 1'b0, 1'b0);
      #1;
      checkOutput("bp_ready_two_b", 32'(up_b.ready), 32'd0);
      checkOutput("bp_hold_b", dn_b.data, 32'd1);
    end
    applyStimulus(1'b1, 32'd3, 1'b1, 1'b0, 1'b0);
    #1;
    checkOutput("bp_out1_b", dn_b.data, 32'd1);
    checkOutput("bp_stall_b", 32'(stall_b), 32'd4);
    checkOutput("bp_stall_c", 32'(stall_c), 32'd4);
    applyStimulus(1'b1, 32'd3, 1'b1, 1'b0, 1'b0);
    #1;
    checkOutput("bp_out2_b", dn_b.data, 32'd2);
    checkOutput("bp_ready_back_b", 32'(up_b.ready), 32'd1);
    applyStimulus(1'b0, '0, 1'b1, 1'b0, 1'b0);
    #1;
    checkOutput("bp_out3_b", dn_b.data, 32'd3);
    applyStimulus(1'b0, '0, 1'b1, 1'b0, 1'b0);
    #1;
    checkOutput("bp_drained_b", 32'(dn_b.valid), 32'd0);
    checkOutput("bp_stall_hold_b", 32'(stall_b), 32'd4);

    // In state ONE, toggling out_ready must not move the skid in_ready.
    applyStimulus(1'b1, 32'h55, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b0);
    #1;
    checkOutput("comb_pre_b", 32'(up_b.ready), 32'd1);
    checkOutput("comb_pre_c", 32'(up_c.ready), 32'd1);
    checkOutput("comb_pre_a", 32'(up_a.ready), 32'd0);
    out_ready = 1'b1;
    #1;
    checkOutput("comb_post_b", 32'(up_b.ready), 32'd1);
    checkOutput("comb_post_c", 32'(up_c.ready), 32'd1);
    checkOutput("comb_post_a", 32'(up_a.ready), 32'd1);

    // Flush with 0xA,0xB held and 0xC offered; 0xD follows.
    applyStimulus(1'b1, 32'hA, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'hB, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'hC, 1'b0, 1'b1, 1'b0);
    #1;
    checkOutput("flush_pre_head_b", dn_b.data, 32'hA);
    checkOutput("flush_pre_ready_b", 32'(up_b.ready), 32'd0);
    applyStimulus(1'b1, 32'hD, 1'b1, 1'b0, 1'b0);
    #1;
    checkOutput("flush_valid_a", 32'(dn_a.valid), 32'd0);
    checkOutput("flush_valid_b", 32'(dn_b.valid), 32'd0);
    checkOutput("flush_valid_c", 32'(dn_c.valid), 32'd0);
    applyStimulus(1'b0, '0, 1'b1, 1'b0, 1'b0);
    #1;
    checkOutput("flush_next_b", dn_b.data, 32'hD);
    checkOutput("flush_next_a", dn_a.data, 32'hD);
    checkOutput("flush_next_valid_c", 32'(dn_c.valid), 32'd1);
    applyStimulus(1'b0, '0, 1'b1, 1'b0, 1'b0);

    // Counter saturation on the 4-bit counter, then clear during a stall.
    applyStimulus(1'b0, '0, 1'b1, 1'b0, 1'b1);
    applyStimulus(1'b1, 32'h77, 1'b0, 1'b0, 1'b0);
    #1;
    checkOutput("sat_cleared_c", 32'(stall_c), 32'd0);
    checkOutput("sat_cleared_b", 32'(stall_b), 32'd0);
    for (int i = 0; i < 20; i++) begin
      applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b0);
    end
    applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b1);
    #1;
    checkOutput("sat_max_c", 32'(stall_c), 32'd15);
    checkOutput("sat_count_b", 32'(stall_b), 32'd20);
    checkOutput("sat_data_c", dn_c.data, 32'h77);
    applyStimulus(1'b0, '0, 1'b1, 1'b0, 1'b0);
    #1;
    checkOutput("clr_wins_c", 32'(stall_c), 32'd0);
    checkOutput("clr_wins_b", 32'(stall_b), 32'd0);
    applyStimulus(1'b0, '0, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, '0, 1'b1, 1'b0, 1'b0);

    @(posedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
